// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter (instruction fetch and data) in front of a single
// fixed-latency memory port. One access is in flight at a time and walks the
// states IDLE -> ISSUE -> WAIT -> DONE. Data requests win ties, but after
// STARVE_MAX back-to-back data grants with fetch waiting, fetch is granted.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_ack              fetch read data, one-cycle done pulse
//   dm_req/dm_we/dm_addr/dm_wdata data request, write flag, address, data
//   dm_rdata/dm_ack              data read data, one-cycle done pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write enable, addr, data
//   mem_rdata                    memory read data, valid MEM_LAT cycles after mem_en
//   busy                         high whenever the FSM is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic            start_s;
  logic            grant_dm_s;
  logic            wait_done_s;
  logic            owner_dm_r;
  logic            we_lat_r;
  logic [2:0]      cnt_r;
  logic [SW-1:0]   streak_r;

  logic            mem_en_r;
  logic            mem_we_r;
  logic [AW-1:0]   mem_addr_r;
  logic [DW-1:0]   mem_wdata_r;
  logic            busy_r;
  logic            if_ack_r;
  logic            dm_ack_r;
  logic [DW-1:0]   if_rdata_r;
  logic [DW-1:0]   dm_rdata_r;

  // WAIT covers MEM_LAT cycles; cnt_r is cleared in ISSUE and steps in WAIT.
  assign wait_done_s = (cnt_r == 3'(MEM_LAT - 1));

  // Next-state and arbitration decision.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    grant_dm_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_nx_s = ST_ISSUE;
          start_s    = 1'b1;
          // Data wins unless fetch has already waited through STARVE_MAX data grants.
          grant_dm_s = dm_req && !(if_req && (streak_r == SW'(STARVE_MAX)));
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_done_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Access latch, starvation counter, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm_r  <= 1'b0;
      we_lat_r    <= 1'b0;
      cnt_r       <= 3'd0;
      streak_r    <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      if_ack_r    <= 1'b0;
      dm_ack_r    <= 1'b0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses unless set below.
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
      if_ack_r <= 1'b0;
      dm_ack_r <= 1'b0;
      busy_r   <= (state_nx_s != ST_IDLE);

      if (start_s) begin
        // mem_addr_r/mem_wdata_r double as the latched request, so they
        // stay stable for the rest of the access.
        owner_dm_r  <= grant_dm_s;
        we_lat_r    <= grant_dm_s && dm_we;
        mem_en_r    <= 1'b1;
        mem_we_r    <= grant_dm_s && dm_we;
        mem_addr_r  <= grant_dm_s ? dm_addr : if_addr;
        mem_wdata_r <= grant_dm_s ? dm_wdata : '0;
        if (grant_dm_s && if_req) begin
          if (streak_r != SW'(STARVE_MAX)) begin
            streak_r <= streak_r + SW'(1);
          end else begin
            streak_r <= streak_r;
          end
        end else begin
          streak_r <= '0;
        end
      end else begin
        streak_r <= streak_r;
      end

      if (state_r == ST_ISSUE) begin
        cnt_r <= 3'd0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      // Last WAIT cycle: capture read data so it and the ack appear in DONE.
      if ((state_r == ST_WAIT) && wait_done_s) begin
        if (owner_dm_r) begin
          dm_ack_r <= 1'b1;
          if (!we_lat_r) begin
            dm_rdata_r <= mem_rdata;
          end else begin
            dm_rdata_r <= dm_rdata_r;
          end
        end else begin
          if_ack_r   <= 1'b1;
          if_rdata_r <= mem_rdata;
        end
      end else begin
        if_rdata_r <= if_rdata_r;
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign if_ack    = if_ack_r;
  assign dm_ack    = dm_ack_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Instance A uses the default MEM_LAT=2,
// instance B is rebuilt with MEM_LAT=1. Each instance has a small memory
// model whose read data is only valid in the cycle MEM_LAT after mem_en and
// is garbage otherwise. Cycle c=0 is the cycle in which a request is raised;
// outputs are sampled on the falling edge in the middle of each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        model_init;

  // Instance A (MEM_LAT = 2)
  logic        rst_a;
  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [15:0] a_if_addr, a_dm_addr, a_mem_addr;
  logic [31:0] a_if_rdata, a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;

  // Instance B (MEM_LAT = 1)
  logic        rst_b;
  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_if_addr, b_dm_addr, b_mem_addr;
  logic [31:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst_a),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory model A: two-stage read pipeline.
  logic [31:0] mem_a [0:255];
  logic        pa_v1, pa_v2;
  logic [31:0] pa_d1, pa_d2;
  always @(posedge clk) begin
    if (model_init) begin
      mem_a[8'h10] <= 32'h12345678;
      mem_a[8'h30] <= 32'hCAFE0030;
      mem_a[8'h40] <= 32'h44444444;
      pa_v1 <= 1'b0;
      pa_v2 <= 1'b0;
    end else begin
      pa_v1 <= a_mem_en && !a_mem_we;
      pa_d1 <= mem_a[a_mem_addr[7:0]];
      pa_v2 <= pa_v1;
      pa_d2 <= pa_d1;
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    end
  end
  assign a_mem_rdata = pa_v2 ? pa_d2 : 32'hBAD0BAD0;

  // Memory model B: one-stage read pipeline.
  logic [31:0] mem_b [0:255];
  logic        pb_v1;
  logic [31:0] pb_d1;
  always @(posedge clk) begin
    if (model_init) begin
      mem_b[8'h10] <= 32'h12345678;
      mem_b[8'h30] <= 32'hCAFE0030;
      pb_v1 <= 1'b0;
    end else begin
      pb_v1 <= b_mem_en && !b_mem_we;
      pb_d1 <= mem_b[b_mem_addr[7:0]];
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end
  end
  assign b_mem_rdata = pb_v1 ? pb_d1 : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    model_init = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    a_if_req = 1'b0; a_if_addr = 16'h0; a_dm_req = 1'b0; a_dm_we = 1'b0;
    a_dm_addr = 16'h0; a_dm_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 16'h0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_addr = 16'h0; b_dm_wdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_if_rdata", a_if_rdata, 32'h0);
    chk("rst_dm_rdata", a_dm_rdata, 32'h0);
    chk("rst_if_ack", a_if_ack, 32'h0);
    chk("rst_dm_ack", a_dm_ack, 32'h0);
    chk("rst_mem_en", a_mem_en, 32'h0);
    chk("rst_mem_we", a_mem_we, 32'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_mem_wdata", a_mem_wdata, 32'h0);
    chk("rst_busy", a_busy, 32'h0);
    chk("rst_b_busy", b_busy, 32'h0);
    model_init = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Fetch read: mem_en in cycle 1, ack in cycle 4, busy 1-4
    a_if_req = 1'b1; a_if_addr = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("fr_mem_en", a_mem_en, (c == 1));
      chk("fr_busy", a_busy, (c >= 1 && c <= 4));
      chk("fr_if_ack", a_if_ack, (c == 4));
      chk("fr_dm_ack", a_dm_ack, 32'h0);
      if (c == 1) begin
        chk("fr_mem_addr", a_mem_addr, 32'h0010);
        chk("fr_mem_we", a_mem_we, 32'h0);
      end
      if (c == 4) begin
        chk("fr_if_rdata", a_if_rdata, 32'h12345678);
        a_if_req = 1'b0;
      end
    end

    // Data write: mem_we in cycle 1 only, dm_ack in cycle 4, dm_rdata unchanged
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 16'h0020; a_dm_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("wr_mem_en", a_mem_en, (c == 1));
      chk("wr_mem_we", a_mem_we, (c == 1));
      chk("wr_dm_ack", a_dm_ack, (c == 4));
      chk("wr_if_ack", a_if_ack, 32'h0);
      if (c == 1) begin
        chk("wr_mem_addr", a_mem_addr, 32'h0020);
        chk("wr_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
      end
      if (c == 4) begin
        chk("wr_dm_rdata", a_dm_rdata, 32'h0);
        a_dm_req = 1'b0; a_dm_we = 1'b0;
      end
    end

    // Data read back of the written word; fetch data holds
    a_dm_req = 1'b1; a_dm_addr = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("rd_mem_en", a_mem_en, (c == 1));
      chk("rd_mem_we", a_mem_we, 32'h0);
      chk("rd_dm_ack", a_dm_ack, (c == 4));
      if (c == 4) begin
        chk("rd_dm_rdata", a_dm_rdata, 32'hDEADBEEF);
        chk("rd_if_rdata_hold", a_if_rdata, 32'h12345678);
        a_dm_req = 1'b0;
      end
    end

    // Tie: dm first (ack 4), fetch ack 5 cycles later (ack 9)
    a_dm_req = 1'b1; a_dm_addr = 16'h0030; a_if_req = 1'b1; a_if_addr = 16'h0040;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("tie_dm_ack", a_dm_ack, (c == 4));
      chk("tie_if_ack", a_if_ack, (c == 9));
      chk("tie_mem_en", a_mem_en, (c == 1 || c == 6));
      if (c == 1) chk("tie_addr1", a_mem_addr, 32'h0030);
      if (c == 6) chk("tie_addr2", a_mem_addr, 32'h0040);
      if (c == 4) begin
        chk("tie_dm_rdata", a_dm_rdata, 32'hCAFE0030);
        a_dm_req = 1'b0;
      end
      if (c == 9) begin
        chk("tie_if_rdata", a_if_rdata, 32'h44444444);
        a_if_req = 1'b0;
      end
    end

    // Starvation: 4 dm grants, then fetch; streak cleared so 4 more dm, then fetch
    a_dm_req = 1'b1; a_dm_addr = 16'h0030; a_if_req = 1'b1; a_if_addr = 16'h0010;
    for (int c = 1; c <= 50; c++) begin
      logic exp_if;
      logic exp_dm;
      @(negedge clk);
      exp_if = (c == 24 || c == 49);
      exp_dm = ((c % 5) == 4) && !exp_if;
      chk("stv_if_ack", a_if_ack, exp_if);
      chk("stv_dm_ack", a_dm_ack, exp_dm);
      if (c == 24) begin
        chk("stv_if_rdata", a_if_rdata, 32'h12345678);
        a_if_req = 1'b0;
      end
      if (c == 25) a_if_req = 1'b1;
      if (c == 49) begin
        a_if_req = 1'b0; a_dm_req = 1'b0;
      end
    end

    // Reset during WAIT: no ack, outputs zero, late memory data ignored
    a_if_req = 1'b1; a_if_addr = 16'h0040;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("rw_busy_wait", a_busy, 32'h1);
        rst_a = 1'b1;
      end
      if (c >= 3) begin
        chk("rw_busy", a_busy, 32'h0);
        chk("rw_if_ack", a_if_ack, 32'h0);
        chk("rw_mem_en", a_mem_en, 32'h0);
      end
      if (c == 3) begin
        chk("rw_if_rdata", a_if_rdata, 32'h0);
        chk("rw_dm_rdata", a_dm_rdata, 32'h0);
        rst_a = 1'b0; a_if_req = 1'b0;
      end
    end
    a_if_req = 1'b1; a_if_addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("ar_if_ack", a_if_ack, (c == 4));
      if (c == 4) begin
        chk("ar_if_rdata", a_if_rdata, 32'h12345678);
        a_if_req = 1'b0;
      end
    end

    // MEM_LAT=1: single read, ack in cycle 3
    b_if_req = 1'b1; b_if_addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("l1_mem_en", b_mem_en, (c == 1));
      chk("l1_if_ack", b_if_ack, (c == 3));
      chk("l1_busy", b_busy, (c <= 3));
      if (c == 1) chk("l1_mem_addr", b_mem_addr, 32'h0010);
      if (c == 3) begin
        chk("l1_if_rdata", b_if_rdata, 32'h12345678);
        b_if_req = 1'b0;
      end
    end

    // MEM_LAT=1: back-to-back dm reads with one IDLE cycle between
    b_dm_req = 1'b1; b_dm_addr = 16'h0030;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_mem_en", b_mem_en, (c == 1 || c == 5));
      chk("b2b_dm_ack", b_dm_ack, (c == 3 || c == 7));
      chk("b2b_busy", b_busy, (c != 4 && c != 8));
      if (c == 3) chk("b2b_dm_rdata", b_dm_rdata, 32'hCAFE0030);
      if (c == 7) b_dm_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, legal 1-7: cycles from the mem_en cycle to mem_rdata valid.
REQ-004 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while fetch waits.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  instruction-fetch request.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetch read data.
- if_ack  out  1  fetch done, one-cycle pulse.
- dm_req  in  1  data request (LOD/STR/SWP).
- dm_we  in  1  data write when 1.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  data write value.
- dm_rdata  out  DW  data read data.
- dm_ack  out  1  data done, one-cycle pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high when state is not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-007 IDLE SHALL go to ISSUE when if_req or dm_req is 1; otherwise it SHALL stay in IDLE.
REQ-008 On leaving IDLE, SHALL latch the winner (owner), its address, dm_we and dm_wdata; later input changes SHALL be ignored until DONE.
REQ-009 Arbitration: dm wins ties unless streak==STARVE_MAX, in which case fetch wins.
REQ-010 streak SHALL increment on a dm grant with if_req=1, saturating at STARVE_MAX; it SHALL clear on an if grant or any grant with if_req=0.
REQ-011 ISSUE SHALL last exactly one cycle: mem_en=1, mem_addr/mem_wdata from latch, mem_we=latched dm_we for dm and 0 for if; then go to WAIT.
REQ-012 mem_en and mem_we SHALL be 0 in every state except ISSUE.
REQ-013 WAIT SHALL count MEM_LAT cycles from the ISSUE cycle, sample mem_rdata on the edge ending the last count cycle, then go to DONE.
REQ-014 DONE SHALL last one cycle: owner's ack=1 and owner's rdata updated (reads only); then go to IDLE.
REQ-015 Latency: req first seen in IDLE cycle 0 -> ISSUE cycle 1 -> ack in cycle MEM_LAT+2; with default, ack in cycle 4.
REQ-016 dm writes SHALL take the same latency and SHALL pulse dm_ack; dm_rdata SHALL remain unchanged.
REQ-017 if_rdata/dm_rdata SHALL hold their last value until the next read completion on that port.
REQ-018 Requesters SHALL hold req and inputs stable until ack and deassert on the edge ending the ack cycle; a req still high in IDLE is a new request.
REQ-019 Requests arriving in ISSUE/WAIT/DONE SHALL stay pending, serviced from the next IDLE; no request SHALL be lost.
REQ-020 if_ack and dm_ack SHALL never be 1 in the same cycle.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, clear streak and owner, and zero all outputs including rdata.
REQ-022 rst during ISSUE/WAIT/DONE SHALL abandon the access with no ack; mem_rdata arriving later SHALL be ignored.
REQ-023 rst SHALL override all requests in the same cycle.

Verification
REQ-024 Fetch read: MEM_LAT=2, if_req, if_addr=0x0010, mem returns 0x12345678 -> mem_en in cycle 1 only, if_ack in cycle 4, if_rdata=0x12345678, busy cycles 1-4.
REQ-025 Data write: dm_req, dm_we=1, dm_addr=0x0020, dm_wdata=0xDEADBEEF -> cycle 1 mem_we=1, mem_addr=0x0020, mem_wdata=0xDEADBEEF; dm_ack cycle 4; dm_rdata unchanged.
REQ-026 Tie: if_req and dm_req both high in IDLE with streak 0 -> dm served first, if_ack 5 cycles after dm_ack, never same cycle.
REQ-027 Starvation: dm_req held continuously, if_req high -> exactly 4 dm grants, then if grant; streak returns to 0.
REQ-028 Reset mid-access: rst in WAIT -> next cycle IDLE, busy=0, no ack, rdata=0; a request after reset is served normally.
REQ-029 MEM_LAT=1 rebuild: single read -> ack in cycle 3, data correct; back-to-back dm reads -> one IDLE cycle between accesses.
